// File: rtl/text_console_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | text_console_ctrl: ASCII stream to 80x30 text RAM sequencer (cursor,      |
// | control codes, screen/row clear); RAM written only during blanking.       |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module text_console_ctrl #(
    parameter int          COLS       = 80,
    parameter int          ROWS       = 30,
    parameter int          ADDR_W     = 12,
    parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_char,
    input  logic              blank,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_data,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);

    localparam logic [1:0] S_CLEAR_ALL = 2'd0;
    localparam logic [1:0] S_IDLE      = 2'd1;
    localparam logic [1:0] S_WRITE     = 2'd2;
    localparam logic [1:0] S_CLEAR_ROW = 2'd3;

    localparam logic [ADDR_W-1:0] LAST_CELL    = ADDR_W'(COLS*ROWS-1);
    localparam logic [ADDR_W-1:0] LAST_COL_IDX = ADDR_W'(COLS-1);
    localparam logic [ADDR_W-1:0] ROW_STEP     = ADDR_W'(COLS);
    localparam logic [6:0]        LAST_COL     = 7'(COLS-1);
    localparam logic [4:0]        LAST_ROW     = 5'(ROWS-1);

    logic [1:0]        state;
    logic [6:0]        col;
    logic [4:0]        row;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        wr_char;
    logic              bs_pending;
    logic [4:0]        next_row;
    logic [ADDR_W-1:0] next_row_base;

    // Row wrap goes back to the top with no scrolling.
    always_comb begin
        next_row      = (row == LAST_ROW) ? 5'd0 : row + 5'd1;
        next_row_base = (row == LAST_ROW) ? '0 : row_base + ROW_STEP;
    end

    always_comb begin
        case (state)
            S_CLEAR_ALL: ram_addr = idx;
            S_WRITE:     ram_addr = row_base + ADDR_W'(col);
            default:     ram_addr = row_base + idx;
        endcase
    end

    assign ram_data   = (state == S_WRITE) ? wr_char : BLANK_CHAR;
    // Reset gating keeps the strobe low while held in reset, even with blank=1.
    assign ram_we     = blank & (state != S_IDLE) & rst_n;
    assign in_ready   = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign cursor_col = col;
    assign cursor_row = row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_CLEAR_ALL;
            col        <= 7'd0;
            row        <= 5'd0;
            row_base   <= '0;
            idx        <= '0;
            wr_char    <= BLANK_CHAR;
            bs_pending <= 1'b0;
        end else begin
            case (state)
                S_CLEAR_ALL: begin
                    if (blank) begin
                        if (idx == LAST_CELL) begin
                            idx      <= '0;
                            col      <= 7'd0;
                            row      <= 5'd0;
                            row_base <= '0;
                            state    <= S_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    if (in_valid) begin
                        if (in_char >= 8'h20 && in_char <= 8'h7E) begin
                            wr_char    <= in_char;
                            bs_pending <= 1'b0;
                            state      <= S_WRITE;
                        end else begin
                            case (in_char)
                                8'h0D: col <= 7'd0;
                                8'h0A: begin
                                    col      <= 7'd0;
                                    row      <= next_row;
                                    row_base <= next_row_base;
                                    idx      <= '0;
                                    state    <= S_CLEAR_ROW;
                                end
                                8'h08: begin
                                    if (col != 7'd0) begin
                                        col        <= col - 7'd1;
                                        wr_char    <= BLANK_CHAR;
                                        bs_pending <= 1'b1;
                                        state      <= S_WRITE;
                                    end
                                end
                                8'h0C: begin
                                    idx      <= '0;
                                    col      <= 7'd0;
                                    row      <= 5'd0;
                                    row_base <= '0;
                                    state    <= S_CLEAR_ALL;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_WRITE: begin
                    if (blank) begin
                        if (bs_pending) begin
                            state <= S_IDLE;
                        end else if (col != LAST_COL) begin
                            col   <= col + 7'd1;
                            state <= S_IDLE;
                        end else begin
                            col      <= 7'd0;
                            row      <= next_row;
                            row_base <= next_row_base;
                            idx      <= '0;
                            state    <= S_CLEAR_ROW;
                        end
                    end
                end
                default: begin
                    if (blank) begin
                        if (idx == LAST_COL_IDX) begin
                            idx   <= '0;
                            state <= S_IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_console_ctrl.sv
`default_nettype none
// Testbench for text_console_ctrl: directed and random byte streams checked
// against a screen-level model of expected RAM writes and cursor position.
module tb_text_console_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic        blank;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [7:0]  ram_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    text_console_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_char(in_char), .blank(blank), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_data(ram_data), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int blank_mode = 0;
    int pat = 0;
    int m_col = 0;
    int m_row = 0;

    logic [11:0] got_addr[$];
    logic [7:0]  got_data[$];
    logic [11:0] exp_addr[$];
    logic [7:0]  exp_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Blank generator: 0 = always on, 1 = random 75%, 2 = 3 on / 5 off
    always @(posedge clk) begin
        #1;
        case (blank_mode)
            0: blank = 1'b1;
            1: blank = (($urandom % 4) != 0);
            default: begin
                blank = (pat < 3);
                pat = (pat + 1) % 8;
            end
        endcase
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ram_we === 1'b1) begin
            chk("we_only_in_blank", {31'd0, blank}, 32'd1);
            got_addr.push_back(ram_addr);
            got_data.push_back(ram_data);
        end
    end

    function automatic void push_exp(input int a, input logic [7:0] d);
        exp_addr.push_back(12'(a));
        exp_data.push_back(d);
    endfunction

    function automatic void new_line();
        m_col = 0;
        m_row = (m_row + 1) % 30;
        for (int i = 0; i < 80; i++) push_exp(m_row * 80 + i, 8'h20);
    endfunction

    function automatic void model_clear_screen();
        for (int i = 0; i < 2400; i++) push_exp(i, 8'h20);
        m_col = 0;
        m_row = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_exp(m_row * 80 + m_col, c);
            if (m_col < 79) m_col++;
            else new_line();
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h0A) begin
            new_line();
        end else if (c == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_exp(m_row * 80 + m_col, 8'h20);
            end
        end else if (c == 8'h0C) begin
            model_clear_screen();
        end
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 30000);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic send(input logic [7:0] c);
        int n = 0;
        while (in_ready !== 1'b1 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30000) chk("send_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_char  = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_char  = 8'($urandom);
        model_byte(c);
    endtask

    task automatic check_writes(input string tag);
        int n;
        bit mism = 0;
        chk({tag, "_count"}, got_addr.size(), exp_addr.size());
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) begin
                chk({tag, "_addr"}, {20'd0, got_addr[i]}, {20'd0, exp_addr[i]});
                chk({tag, "_data"}, {24'd0, got_data[i]}, {24'd0, exp_data[i]});
                mism = 1;
                break;
            end
        end
        if (!mism && n > 0) begin
            chk({tag, "_last_addr"}, {20'd0, got_addr[n-1]}, {20'd0, exp_addr[n-1]});
            chk({tag, "_last_data"}, {24'd0, got_data[n-1]}, {24'd0, exp_data[n-1]});
        end
        chk({tag, "_col"}, {25'd0, cursor_col}, 32'(m_col));
        chk({tag, "_row"}, {27'd0, cursor_row}, 32'(m_row));
        got_addr.delete(); got_data.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    initial begin
        logic [7:0] c;
        int r;
        rst_n = 1'b0; in_valid = 1'b0; in_char = 8'h00; blank = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_col", {25'd0, cursor_col}, 32'd0);
        chk("rst_row", {27'd0, cursor_row}, 32'd0);

        // Power-up clear
        rst_n = 1'b1;
        model_clear_screen();
        wait_idle("powerup");
        chk("powerup_first_addr", (got_addr.size() > 0) ? {20'd0, got_addr[0]} : 32'hFFFF, 32'd0);
        check_writes("powerup");
        chk("powerup_ready", {31'd0, in_ready}, 32'd1);

        // Single printable with latency check
        in_valid = 1'b1; in_char = 8'h41;
        @(posedge clk); #1 in_valid = 1'b0;
        model_byte(8'h41);
        @(negedge clk);
        chk("lat_we", {31'd0, ram_we}, 32'd1);
        chk("lat_addr", {20'd0, ram_addr}, 32'd0);
        chk("lat_data", {24'd0, ram_data}, 32'h41);
        chk("lat_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("lat_ready_high", {31'd0, in_ready}, 32'd1);
        check_writes("char_A");

        // Bottom-right corner write wraps to the top row
        send(8'h0C); wait_idle("ff1"); check_writes("ff1");
        for (int i = 0; i < 29; i++) send(8'h0A);
        for (int i = 0; i < 79; i++) send(8'h61 + 8'(i % 26));
        wait_idle("fill"); check_writes("fill");
        send(8'h5A); wait_idle("corner");
        chk("corner_first_addr", (got_addr.size() > 0) ? {20'd0, got_addr[0]} : 32'hFFFF, 32'd2399);
        check_writes("corner");

        // Clear screen under a 3-on/5-off blanking pattern
        blank_mode = 2;
        send(8'h0C); wait_idle("ff_gated"); check_writes("ff_gated");

        // Backspace and carriage return
        blank_mode = 1;
        send(8'h0C); send(8'h0A); send(8'h0A);
        send(8'h61); send(8'h62); send(8'h63);
        wait_idle("pos32"); check_writes("pos32");
        send(8'h08); wait_idle("bs");
        chk("bs_addr", (got_addr.size() > 0) ? {20'd0, got_addr[0]} : 32'hFFFF, 32'd162);
        check_writes("bs");
        send(8'h0D); wait_idle("cr"); check_writes("cr");
        send(8'h0D); send(8'h08); wait_idle("bs_col0"); check_writes("bs_col0");

        // Random stream
        for (int k = 0; k < 150; k++) begin
            r = $urandom % 100;
            if (r < 70)      c = 8'h20 + 8'($urandom % 95);
            else if (r < 78) c = 8'h0A;
            else if (r < 84) c = 8'h0D;
            else if (r < 92) c = 8'h08;
            else if (r < 98) c = ($urandom % 2) ? (8'h80 | 8'($urandom % 128)) : 8'h7F;
            else             c = 8'h0C;
            send(c);
            wait_idle("rand");
            check_writes("rand");
        end

        // Reset in the middle of a row clear
        blank_mode = 0;
        send(8'h0A);
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_we", {31'd0, ram_we}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        chk("midrst_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_col", {25'd0, cursor_col}, 32'd0);
        chk("midrst_row", {27'd0, cursor_row}, 32'd0);
        got_addr.delete(); got_data.delete();
        exp_addr.delete(); exp_data.delete();
        @(negedge clk);
        rst_n = 1'b1;
        model_clear_screen();
        wait_idle("midrst");
        chk("midrst_first_addr", (got_addr.size() > 0) ? {20'd0, got_addr[0]} : 32'hFFFF, 32'd0);
        check_writes("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
